regfile_wport_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file.
- Shares that port between two sources:
  - the pipeline writeback stage, which has priority and is never back-pressured;
  - the multi-cycle mul/div unit, whose results are buffered in a small FIFO.
- Keeps a pending-destination scoreboard so the decode stage can stall on RAW/WAW hazards against in-flight mul/div results.
- Sits between the WB stage, the mul/div unit and the register file write inputs.

---
 rtl/regfile_wport_arbiter_pkg.sv | 19 +
 rtl/regfile_wb_fifo.sv | 51 +++++
 rtl/regfile_wport_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wport_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared widths and the mul/div result record for the register file
// write-port arbiter.
package regfile_wport_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int REG_COUNT  = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     reg_data_t;

   typedef struct packed {
      reg_addr_t dest;
      reg_data_t data;
   } md_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO buffering mul/div results until the write port is
// free; head entry is visible combinationally on dout.
module regfile_wb_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 37,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          wr_en;
   logic          rd_en;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Register file write-port owner: WB has priority, mul/div results queue in
// a FIFO, and a scoreboard flags decode hazards on in-flight mul/div dests.
module regfile_wport_arbiter
   import regfile_wport_arbiter_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   parameter  int STARVE_MAX = 8,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1,
   localparam int SW         = $clog2(STARVE_MAX) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  md_valid,
   output logic                  md_ready,
   input  logic [REG_ADDR_W-1:0] md_dest,
   input  logic [DATA_W-1:0]     md_data,
   input  logic                  md_issue,
   input  logic [REG_ADDR_W-1:0] md_issue_dest,
   input  logic [REG_ADDR_W-1:0] chk_rs,
   input  logic [REG_ADDR_W-1:0] chk_rt,
   input  logic [REG_ADDR_W-1:0] chk_rd,
   input  logic                  chk_rd_valid,
   output logic                  hazard,
   output logic                  pipe_stall,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic [CW-1:0]         pending_cnt
);

   logic                 wb_win;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;
   md_entry_t            in_entry;
   md_entry_t            head;
   logic [REG_COUNT-1:0] sb;
   logic [REG_COUNT-1:0] sb_next;
   logic [SW-1:0]        starve_cnt;

   assign md_ready = !full;
   assign wb_win   = wb_valid && (wb_dest != ZERO_REG);
   // Dest-0 results are acknowledged but never stored.
   assign push     = md_valid && md_ready && (md_dest != ZERO_REG);
   assign pop      = !wb_win && !empty;
   assign in_entry = '{dest: md_dest, data: md_data};

   regfile_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(md_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (in_entry),
      .pop   (pop),
      .dout  (head),
      .count (pending_cnt),
      .full  (full),
      .empty (empty)
   );

   // Set after clear so a same-register issue keeps the bit pending.
   always_comb begin
      sb_next = sb;
      if (pop) sb_next[head.dest] = 1'b0;
      if (md_issue) sb_next[md_issue_dest] = 1'b1;
      sb_next[ZERO_REG] = 1'b0;
   end

   assign hazard = ((chk_rs != ZERO_REG) && sb[chk_rs])
                || ((chk_rt != ZERO_REG) && sb[chk_rt])
                || (chk_rd_valid && (chk_rd != ZERO_REG) && sb[chk_rd]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         pipe_stall <= 1'b0;
         sb         <= '0;
         starve_cnt <= '0;
      end else begin
         sb         <= sb_next;
         rf_we      <= wb_win || pop;
         pipe_stall <= 1'b0;
         if (wb_win) begin
            rf_waddr <= wb_dest;
            rf_wdata <= wb_data;
         end else if (pop) begin
            rf_waddr <= head.dest;
            rf_wdata <= head.data;
         end
         // Non-empty without a pop means WB took the port this cycle.
         if (empty || pop) begin
            starve_cnt <= '0;
         end else if (starve_cnt == SW'(STARVE_MAX - 1)) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b1;
         end else begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for the write-port arbiter: reset, FIFO path, hazards,
// starvation, back-pressure, zero-register traffic and mid-stream reset.
module tb_regfile_wport_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic        md_valid;
   logic        md_ready;
   logic [4:0]  md_dest;
   logic [31:0] md_data;
   logic        md_issue;
   logic [4:0]  md_issue_dest;
   logic [4:0]  chk_rs;
   logic [4:0]  chk_rt;
   logic [4:0]  chk_rd;
   logic        chk_rd_valid;
   logic        hazard;
   logic        pipe_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [2:0]  pending_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_wport_arbiter #(
      .FIFO_DEPTH (4),
      .STARVE_MAX (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wb_valid      (wb_valid),
      .wb_dest       (wb_dest),
      .wb_data       (wb_data),
      .md_valid      (md_valid),
      .md_ready      (md_ready),
      .md_dest       (md_dest),
      .md_data       (md_data),
      .md_issue      (md_issue),
      .md_issue_dest (md_issue_dest),
      .chk_rs        (chk_rs),
      .chk_rt        (chk_rt),
      .chk_rd        (chk_rd),
      .chk_rd_valid  (chk_rd_valid),
      .hazard        (hazard),
      .pipe_stall    (pipe_stall),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .pending_cnt   (pending_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      wb_valid = 0; wb_dest = 0; wb_data = 0;
      md_valid = 0; md_dest = 0; md_data = 0;
      md_issue = 0; md_issue_dest = 0;
      chk_rs = 0; chk_rt = 0; chk_rd = 0; chk_rd_valid = 0;
      tick();
      tick();
      chk("rst_we", 32'(rf_we), 0);
      chk("rst_waddr", 32'(rf_waddr), 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_stall", 32'(pipe_stall), 0);
      chk("rst_cnt", 32'(pending_cnt), 0);
      chk("rst_ready", 32'(md_ready), 1);
      chk("rst_hazard", 32'(hazard), 0);
      reset = 1'b1;
      tick();

      // single mul/div result through the FIFO
      md_valid = 1; md_dest = 5; md_data = 32'hDEAD;
      tick();
      md_valid = 0;
      chk("t1_cnt1", 32'(pending_cnt), 1);
      chk("t1_we0", 32'(rf_we), 0);
      tick();
      chk("t1_we", 32'(rf_we), 1);
      chk("t1_waddr", 32'(rf_waddr), 5);
      chk("t1_wdata", rf_wdata, 32'hDEAD);
      chk("t1_cnt0", 32'(pending_cnt), 0);
      tick();
      chk("t1_idle_we", 32'(rf_we), 0);
      chk("t1_hold_addr", 32'(rf_waddr), 5);

      // scoreboard hazard on rs
      md_issue = 1; md_issue_dest = 7; chk_rs = 7;
      chk("t2_pre_hz", 32'(hazard), 0);
      tick();
      md_issue = 0;
      chk("t2_hz_set", 32'(hazard), 1);
      md_valid = 1; md_dest = 7; md_data = 32'h77;
      tick();
      md_valid = 0;
      chk("t2_hz_queued", 32'(hazard), 1);
      tick();
      chk("t2_we7", 32'(rf_waddr), 7);
      chk("t2_hz_clr", 32'(hazard), 0);
      chk_rs = 0;

      // starvation: WB keeps the port while one entry waits
      wb_valid = 1; wb_dest = 3; wb_data = 32'h33;
      md_valid = 1; md_dest = 11; md_data = 32'hBB;
      tick();
      md_valid = 0;
      chk("t3_wb_first", 32'(rf_waddr), 3);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("t3_no_stall", 32'(pipe_stall), 0);
      end
      tick();
      chk("t3_stall", 32'(pipe_stall), 1);
      chk("t3_cnt", 32'(pending_cnt), 1);
      wb_valid = 0;
      tick();
      chk("t3_stall_pulse", 32'(pipe_stall), 0);
      chk("t3_pop_addr", 32'(rf_waddr), 11);
      chk("t3_pop_data", rf_wdata, 32'hBB);
      chk("t3_cnt0", 32'(pending_cnt), 0);

      // back-pressure with a full FIFO
      wb_valid = 1; wb_dest = 3; wb_data = 32'h33;
      for (int i = 0; i < 4; i++) begin
         md_valid = 1; md_dest = 5'(12 + i); md_data = 32'hC0 + i;
         tick();
      end
      chk("t4_full_cnt", 32'(pending_cnt), 4);
      chk("t4_not_ready", 32'(md_ready), 0);
      md_dest = 16; md_data = 32'hC4;
      tick();
      chk("t4_held_cnt", 32'(pending_cnt), 4);
      wb_valid = 0;
      tick();
      chk("t4_pop12", 32'(rf_waddr), 12);
      chk("t4_cnt3a", 32'(pending_cnt), 3);
      chk("t4_ready", 32'(md_ready), 1);
      tick();
      md_valid = 0;
      chk("t4_pop13", 32'(rf_waddr), 13);
      chk("t4_cnt3b", 32'(pending_cnt), 3);
      tick();
      chk("t4_pop14", 32'(rf_waddr), 14);
      tick();
      chk("t4_pop15", 32'(rf_waddr), 15);
      tick();
      chk("t4_pop16", 32'(rf_waddr), 16);
      chk("t4_data16", rf_wdata, 32'hC4);
      chk("t4_cnt0", 32'(pending_cnt), 0);

      // zero-register traffic
      wb_valid = 1; wb_dest = 3; wb_data = 32'h33;
      md_valid = 1; md_dest = 20; md_data = 32'h20;
      tick();
      wb_dest = 0; wb_data = 32'h55;
      md_dest = 0; md_data = 32'h66;
      tick();
      chk("t5_fifo_wins", 32'(rf_waddr), 20);
      chk("t5_fifo_data", rf_wdata, 32'h20);
      chk("t5_cnt0", 32'(pending_cnt), 0);
      tick();
      chk("t5_no_we", 32'(rf_we), 0);
      chk("t5_cnt_drop", 32'(pending_cnt), 0);
      chk_rs = 3; chk_rt = 20;
      #1;
      chk("t5_sb_clean", 32'(hazard), 0);
      wb_valid = 0; md_valid = 0; chk_rs = 0; chk_rt = 0;

      // reset mid-stream
      md_issue = 1; md_issue_dest = 4;
      tick();
      md_issue_dest = 9;
      tick();
      md_issue = 0;
      chk_rd = 9; chk_rd_valid = 0;
      #1;
      chk("t6_rd_gated", 32'(hazard), 0);
      chk_rd_valid = 1;
      #1;
      chk("t6_rd_hz", 32'(hazard), 1);
      chk_rd_valid = 0; chk_rt = 9;
      #1;
      chk("t6_rt_hz", 32'(hazard), 1);
      chk_rt = 0; chk_rs = 4;
      wb_valid = 1; wb_dest = 3; wb_data = 32'h33;
      for (int i = 0; i < 3; i++) begin
         md_valid = 1;
         md_dest = (i == 0) ? 5'd4 : (i == 1) ? 5'd9 : 5'd21;
         md_data = 32'hE0 + i;
         tick();
      end
      md_valid = 0;
      chk("t6_cnt3", 32'(pending_cnt), 3);
      chk("t6_hz_rs", 32'(hazard), 1);
      reset = 1'b0;
      #1;
      chk("t6_we", 32'(rf_we), 0);
      chk("t6_waddr", 32'(rf_waddr), 0);
      chk("t6_wdata", rf_wdata, 0);
      chk("t6_cnt", 32'(pending_cnt), 0);
      chk("t6_ready", 32'(md_ready), 1);
      chk("t6_hz", 32'(hazard), 0);
      wb_valid = 0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6_no_stale", 32'(rf_we), 0);
      end
      chk_rs = 9;
      #1;
      chk("t6_sb9_clear", 32'(hazard), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
